blink_tick_ctrl: RTL and testbench

//  Upstream control stage for the LED blink sequencer. Debounces two raw push-buttons
//  (speed, pause), keeps a 2-bit rate index and a run flag, and emits a 1-cycle
//  `tick` pulse at the selected rate. The sequencer advances one LED step per tick,

---
 rtl/blink_pkg.sv | 20 ++
 rtl/btn_debounce.sv | 97 +++++++++
 rtl/blink_tick_ctrl.sv | 93 +++++++++
 tb/tb_blink_tick_ctrl.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/blink_pkg.sv
// Shared definitions for the LED blink control path and its sequencer.
package blink_pkg;

    // Width of the rate index; the sequencer uses the same width.
    localparam int RATE_W = 2;

    // Debounce FSM states, shared by both button channels.
    typedef enum logic [1:0] {
        RELEASED,
        CHK_PRESS,
        PRESSED,
        CHK_RELEASE
    } db_state_t;

    // Step the rate index, wrapping from the fastest rate back to the slowest.
    function automatic logic [RATE_W-1:0] nextRate(input logic [RATE_W-1:0] rate);
        return rate + RATE_W'(1);
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchronizer plus debounce FSM for one raw push-button.
// Emits a single-cycle press pulse once the button has been stably high long enough.
module btn_debounce
    import blink_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int CNT_W           = 32
)
(
    input  logic clk,
    input  logic rst,
    input  logic btn_raw,
    output logic press
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             r_sync1;
    logic             r_sync2;
    db_state_t        r_state;
    db_state_t        w_nextState;
    logic [CNT_W-1:0] r_dcnt;
    logic [CNT_W-1:0] w_nextDcnt;
    logic             r_press;
    logic             w_nextPress;

    // Bring the asynchronous button level into the clock domain.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= btn_raw;
            r_sync2 <= r_sync1;
        end
    end

    // Register the FSM state, the stability counter and the press pulse.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= RELEASED;
            r_dcnt  <= '0;
            r_press <= 1'b0;
        end else begin
            r_state <= w_nextState;
            r_dcnt  <= w_nextDcnt;
            r_press <= w_nextPress;
        end
    end

    // Decide the next state; a press pulse only fires on the CHK_PRESS -> PRESSED step.
    always_comb begin
        w_nextState = r_state;
        w_nextDcnt  = r_dcnt;
        w_nextPress = 1'b0;
        case (r_state)
            RELEASED: begin
                if (r_sync2) begin
                    w_nextState = CHK_PRESS;
                    w_nextDcnt  = '0;
                end
            end
            CHK_PRESS: begin
                if (!r_sync2) begin
                    w_nextState = RELEASED;
                end else if (r_dcnt == LAST_CNT) begin
                    w_nextState = PRESSED;
                    w_nextPress = 1'b1;
                end else begin
                    w_nextDcnt = r_dcnt + CNT_W'(1);
                end
            end
            PRESSED: begin
                if (!r_sync2) begin
                    w_nextState = CHK_RELEASE;
                    w_nextDcnt  = '0;
                end
            end
            CHK_RELEASE: begin
                if (r_sync2) begin
                    w_nextState = PRESSED;
                end else if (r_dcnt == LAST_CNT) begin
                    w_nextState = RELEASED;
                end else begin
                    w_nextDcnt = r_dcnt + CNT_W'(1);
                end
            end
            default: begin
                w_nextState = RELEASED;
                w_nextDcnt  = '0;
            end
        endcase
    end

    assign press = r_press;

endmodule

// File: rtl/blink_tick_ctrl.sv
// Control stage for the LED blink sequencer: debounced speed/pause buttons,
// a 2-bit rate index, a run flag and a one-cycle tick at the selected rate.
module blink_tick_ctrl
    import blink_pkg::*;
#(
    parameter int BASE_PERIOD     = 100_000_000,
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int CNT_W           = 32
)
(
    input  logic              clk,
    input  logic              rst,
    input  logic              btn_speed,
    input  logic              btn_pause,
    output logic              tick,
    output logic [RATE_W-1:0] rate_idx,
    output logic              running
);

    localparam logic [CNT_W-1:0] BASE_CNT = CNT_W'(BASE_PERIOD);

    logic              w_speedPress;
    logic              w_pausePress;
    logic [CNT_W-1:0]  w_period;
    logic [CNT_W-1:0]  w_lastCnt;
    logic [RATE_W-1:0] r_rateIdx;
    logic              r_running;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_tick;

    btn_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .CNT_W           (CNT_W)
    ) u_speedDb (
        .clk     (clk),
        .rst     (rst),
        .btn_raw (btn_speed),
        .press   (w_speedPress)
    );

    btn_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .CNT_W           (CNT_W)
    ) u_pauseDb (
        .clk     (clk),
        .rst     (rst),
        .btn_raw (btn_pause),
        .press   (w_pausePress)
    );

    // Each rate step halves the period; the terminal count is one less than the period.
    assign w_period  = BASE_CNT >> r_rateIdx;
    assign w_lastCnt = w_period - CNT_W'(1);

    // Rate index and run flag react to their own button; both may change together.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rateIdx <= '0;
            r_running <= 1'b1;
        end else begin
            if (w_speedPress) begin
                r_rateIdx <= nextRate(r_rateIdx);
            end
            if (w_pausePress) begin
                r_running <= ~r_running;
            end
        end
    end

    // Period counter and tick: a rate change restarts the period, pausing freezes the count.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt  <= '0;
            r_tick <= 1'b0;
        end else if (w_speedPress) begin
            r_cnt  <= '0;
            r_tick <= 1'b0;
        end else if (w_pausePress || !r_running) begin
            r_tick <= 1'b0;
        end else if (r_cnt == w_lastCnt) begin
            r_cnt  <= '0;
            r_tick <= 1'b1;
        end else begin
            r_cnt  <= r_cnt + CNT_W'(1);
            r_tick <= 1'b0;
        end
    end

    assign tick     = r_tick;
    assign rate_idx = r_rateIdx;
    assign running  = r_running;

endmodule

// File: tb/tb_blink_tick_ctrl.sv
// Directed bench for blink_tick_ctrl with a tick-time scoreboard.
// Expected tick cycles are queued when stimulus is applied and popped when tick fires.
module tb_blink_tick_ctrl;
    import blink_pkg::*;

    localparam int BASE     = 16;
    localparam int DEB      = 4;
    localparam int PRESS_DL = DEB + 4;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              btnSpeed = 1'b0;
    logic              btnPause = 1'b0;
    logic              tick;
    logic [RATE_W-1:0] rateIdx;
    logic              running;

    int cyc = 0;
    int compared = 0;
    int mismatched = 0;

    int expQ[$];
    int z = 0;
    int per = BASE;
    int modelRate = 0;
    bit modelRun = 1'b1;
    int pauseEdge = 0;
    int pushedUpTo = 0;

    int speedRates[4] = '{1, 2, 3, 0};

    blink_tick_ctrl #(
        .BASE_PERIOD     (BASE),
        .DEBOUNCE_CYCLES (DEB),
        .CNT_W           (32)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .btn_speed (btnSpeed),
        .btn_pause (btnPause),
        .tick      (tick),
        .rate_idx  (rateIdx),
        .running   (running)
    );

    // Free-running clock and posedge counter used as the time base.
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] expv);
        compared++;
        assert (got === expv) else begin
            mismatched++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, expv);
        end
    endtask

    // Queue every tick the current schedule produces up to and including edge 'limit'.
    task automatic pushUpTo(input int limit);
        if (modelRun) begin
            for (int t = z + per; t <= limit; t += per) begin
                if (t > pushedUpTo) expQ.push_back(t);
            end
        end
        if (limit > pushedUpTo) pushedUpTo = limit;
    endtask

    // Record the effect of debounced presses that land on edge c.
    task automatic scheduleChange(input int c, input bit sp, input bit pa);
        pushUpTo(c - 1);
        if (sp) begin
            modelRate = (modelRate + 1) % 4;
            per       = BASE >> modelRate;
            z         = c;
            pauseEdge = c + 1;
        end
        if (pa) begin
            if (modelRun) begin
                modelRun = 1'b0;
                if (!sp) pauseEdge = c;
            end else begin
                z        = z + c + 1 - pauseEdge;
                modelRun = 1'b1;
            end
        end
    endtask

    task automatic stepTo(input int target);
        if (target < cyc) checkOutput("step_target", cyc, target);
        pushUpTo(target);
        while (cyc < target) @(negedge clk);
    endtask

    task automatic idle(input int n);
        stepTo(cyc + n);
    endtask

    task automatic releaseReset();
        rst        = 1'b1;
        modelRate  = 0;
        modelRun   = 1'b1;
        per        = BASE;
        z          = cyc;
        pushedUpTo = cyc;
    endtask

    // Raise the chosen buttons for 'hold' cycles; cEdge is the edge where the DUT reacts.
    task automatic applyStimulus(input bit sp, input bit pa, input int hold, output int cEdge);
        int n;
        n     = cyc;
        cEdge = n + PRESS_DL;
        scheduleChange(cEdge, sp, pa);
        btnSpeed = sp;
        btnPause = pa;
        stepTo(n + hold);
        btnSpeed = 1'b0;
        btnPause = 1'b0;
    endtask

    // Scoreboard: every tick must match the oldest queued cycle; stale entries are misses.
    always @(negedge clk) begin
        if (rst === 1'b1) begin
            while (expQ.size() > 0 && expQ[0] < cyc) begin
                checkOutput("missed_tick", 0, 1);
                void'(expQ.pop_front());
            end
            if (tick === 1'b1) begin
                if (expQ.size() == 0) checkOutput("unexpected_tick_cycle", cyc, 32'hFFFF_FFFF);
                else checkOutput("tick_cycle", cyc, expQ.pop_front());
            end
        end
    end

    // Hard bound on total simulation time.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int c;
        int cRes;

        // Reset state
        repeat (3) @(negedge clk);
        checkOutput("reset_tick", tick, 0);
        checkOutput("reset_rate", rateIdx, 0);
        checkOutput("reset_running", running, 1);
        releaseReset();

        // Idle ticking at the base period
        $display("[TB] idle cadence");
        idle(64);
        checkOutput("idle_rate", rateIdx, 0);
        checkOutput("idle_running", running, 1);

        // Four speed presses step the rate and wrap
        $display("[TB] speed presses");
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 1'b0, 10, c);
            checkOutput("speed_rate", rateIdx, speedRates[i]);
            idle(40);
        end

        // Short glitch on the speed button must be ignored
        $display("[TB] speed glitch");
        btnSpeed = 1'b1;
        stepTo(cyc + 3);
        btnSpeed = 1'b0;
        idle(40);
        checkOutput("glitch_rate", rateIdx, 0);

        // Pause with the counter at 5, hold off, then resume
        $display("[TB] pause and resume");
        c = z + 6;
        while (c < cyc + PRESS_DL + 1) c += per;
        stepTo(c - PRESS_DL);
        applyStimulus(1'b0, 1'b1, 10, c);
        checkOutput("paused_running", running, 0);
        idle(100);
        checkOutput("still_paused", running, 0);
        applyStimulus(1'b0, 1'b1, 10, cRes);
        checkOutput("resumed_running", running, 1);
        stepTo(cRes + 10);
        checkOutput("resume_gap_10", tick, 0);
        stepTo(cRes + 11);
        checkOutput("resume_first_tick", tick, 1);
        idle(40);

        // Both buttons together
        $display("[TB] simultaneous presses");
        applyStimulus(1'b1, 1'b1, 10, c);
        checkOutput("both_rate", rateIdx, 1);
        checkOutput("both_running", running, 0);
        idle(30);

        // Rate 2 while paused, then asynchronous reset mid-operation
        $display("[TB] reset while paused");
        applyStimulus(1'b1, 1'b0, 10, c);
        checkOutput("paused_rate2", rateIdx, 2);
        idle(20);
        rst = 1'b0;
        #1;
        checkOutput("async_reset_tick", tick, 0);
        checkOutput("async_reset_rate", rateIdx, 0);
        checkOutput("async_reset_running", running, 1);
        @(negedge clk);
        releaseReset();
        idle(40);

        // Reset pulse while the speed debouncer is in CHK_PRESS
        $display("[TB] reset during debounce");
        btnSpeed = 1'b1;
        stepTo(cyc + 4);
        rst = 1'b0;
        @(negedge clk);
        btnSpeed = 1'b0;
        releaseReset();
        idle(40);
        checkOutput("no_press_after_pulse", rateIdx, 0);
        checkOutput("running_after_pulse", running, 1);

        // Pause button held through reset release still yields one press
        $display("[TB] button held through reset");
        btnPause = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        releaseReset();
        scheduleChange(cyc + PRESS_DL, 1'b0, 1'b1);
        idle(12);
        btnPause = 1'b0;
        idle(20);
        checkOutput("held_reset_running", running, 0);
        checkOutput("held_reset_rate", rateIdx, 0);

        // Drain: nothing left pending in the scoreboard
        @(negedge clk);
        #1;
        checkOutput("pending_ticks", expQ.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
